// File: rtl/inv_sqrt_pipe.sv
// Purpose: G.729 Inv_sqrt(L_x) on a word in a 2048x32 RAM; result written back to RAM.
// Latency: 8 cycles from accepted start to done (read 2, norm, lookup, msu, shift, write).
// Backpressure: none; start is ignored while busy, test ports own the RAM when sqrtMuxSel=1.
module inv_sqrt_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] L_xAddr,
  input  logic [10:0] L_yAddr,
  input  logic        sqrtMuxSel,
  input  logic [10:0] testReadAddr,
  input  logic [10:0] testWriteAddr,
  input  logic [31:0] testMemOut,
  input  logic        testMemWriteEn,
  output logic        done,
  output logic [31:0] memIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_NORM, S_LOOKUP, S_MSU, S_SHIFT, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        rd_wait_q, rd_wait_d;
  logic        done_q, done_d;
  logic [10:0] xaddr_q, xaddr_d;
  logic [10:0] yaddr_q, yaddr_d;
  logic [31:0] lx_q, lx_d;
  logic [4:0]  exp_q, exp_d;
  logic [15:0] tab_q, tab_d;
  logic [15:0] dif_q, dif_d;
  logic [14:0] a_q, a_d;
  logic [31:0] ly_q, ly_d;

  logic [31:0] mem [0:2047];
  logic [31:0] rdata_q;
  logic [10:0] ram_raddr, ram_waddr;
  logic [31:0] ram_wdata;
  logic        ram_we;

  logic [4:0]  nrm;
  logic        nrm_found;
  logic [4:0]  exp_raw;
  logic [31:0] lx_norm;
  logic [5:0]  lk_idx, lk_nxt;
  logic signed [47:0] hi_w, prod_w, msu_w;
  logic [31:0] msu_sat;

  // Interpolation table: 1/sqrt over the normalised mantissa range, Q15.
  function automatic logic [15:0] tabsqr(input logic [5:0] idx);
    logic [15:0] t;
    case (idx)
      6'd0:  t = 16'd32767; 6'd1:  t = 16'd31790; 6'd2:  t = 16'd30894; 6'd3:  t = 16'd30070;
      6'd4:  t = 16'd29309; 6'd5:  t = 16'd28602; 6'd6:  t = 16'd27945; 6'd7:  t = 16'd27330;
      6'd8:  t = 16'd26755; 6'd9:  t = 16'd26214; 6'd10: t = 16'd25705; 6'd11: t = 16'd25225;
      6'd12: t = 16'd24770; 6'd13: t = 16'd24339; 6'd14: t = 16'd23930; 6'd15: t = 16'd23541;
      6'd16: t = 16'd23170; 6'd17: t = 16'd22817; 6'd18: t = 16'd22479; 6'd19: t = 16'd22155;
      6'd20: t = 16'd21845; 6'd21: t = 16'd21548; 6'd22: t = 16'd21263; 6'd23: t = 16'd20988;
      6'd24: t = 16'd20724; 6'd25: t = 16'd20470; 6'd26: t = 16'd20225; 6'd27: t = 16'd19988;
      6'd28: t = 16'd19760; 6'd29: t = 16'd19539; 6'd30: t = 16'd19326; 6'd31: t = 16'd19119;
      6'd32: t = 16'd18919; 6'd33: t = 16'd18725; 6'd34: t = 16'd18536; 6'd35: t = 16'd18354;
      6'd36: t = 16'd18176; 6'd37: t = 16'd18004; 6'd38: t = 16'd17837; 6'd39: t = 16'd17674;
      6'd40: t = 16'd17515; 6'd41: t = 16'd17361; 6'd42: t = 16'd17211; 6'd43: t = 16'd17064;
      6'd44: t = 16'd16921; 6'd45: t = 16'd16782; 6'd46: t = 16'd16646; 6'd47: t = 16'd16514;
      default: t = 16'd16384;
    endcase
    return t;
  endfunction

  // RAM port mux: test ports take full ownership whenever sqrtMuxSel is high.
  always_comb begin
    if (sqrtMuxSel) begin
      ram_raddr = testReadAddr;
      ram_waddr = testWriteAddr;
      ram_wdata = testMemOut;
      ram_we    = testMemWriteEn;
    end else begin
      ram_raddr = xaddr_q;
      ram_waddr = yaddr_q;
      ram_wdata = ly_q;
      ram_we    = (state_q == S_WRITE);
    end
  end

  // RAM: synchronous write, registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rdata_q <= mem[ram_raddr];
  end

  assign memIn = rdata_q;
  assign done  = done_q;

  // Normalisation: leading-one search, shift into 0x40000000.., halve on even exponent.
  always_comb begin
    nrm       = '0;
    nrm_found = 1'b0;
    for (int b = 30; b >= 0; b--) begin
      if (!nrm_found && lx_q[b]) begin
        nrm_found = 1'b1;
        nrm       = 5'(30 - b);
      end
    end
    exp_raw = 5'd30 - nrm;
    lx_norm = lx_q << nrm;
    if (!exp_raw[0]) lx_norm = lx_norm >> 1;
  end

  // Multiply-subtract: table value in the high half minus 2*slope*fraction, saturated.
  always_comb begin
    hi_w   = $signed({16'h0000, tab_q, 16'h0000});
    prod_w = $signed({{32{dif_q[15]}}, dif_q}) * $signed({33'd0, a_q});
    msu_w  = hi_w - (prod_w <<< 1);
    if (msu_w > 48'sh0000_7FFF_FFFF)      msu_sat = 32'h7FFF_FFFF;
    else if (msu_w < 48'shFFFF_8000_0000) msu_sat = 32'h8000_0000;
    else                                  msu_sat = msu_w[31:0];
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    rd_wait_d = rd_wait_q;
    done_d    = done_q;
    xaddr_d   = xaddr_q;
    yaddr_d   = yaddr_q;
    lx_d      = lx_q;
    exp_d     = exp_q;
    tab_d     = tab_q;
    dif_d     = dif_q;
    a_d       = a_q;
    ly_d      = ly_q;
    lk_idx    = lx_q[30:25] - 6'd16;
    lk_nxt    = lk_idx + 6'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_READ;
          rd_wait_d = 1'b0;
          done_d    = 1'b0;
          xaddr_d   = L_xAddr;
          yaddr_d   = L_yAddr;
        end
      end
      S_READ: begin
        // First cycle issues the address, second cycle sees the registered word.
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d = 1'b0;
          lx_d      = memIn;
          if ($signed(memIn) <= 32'sd0) begin
            ly_d    = 32'h3FFF_FFFF;
            state_d = S_WRITE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        lx_d    = lx_norm;
        exp_d   = (exp_raw >> 1) + 5'd1;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        tab_d   = tabsqr(lk_idx);
        dif_d   = tabsqr(lk_idx) - tabsqr(lk_nxt);
        a_d     = lx_q[24:10];
        state_d = S_MSU;
      end
      S_MSU: begin
        ly_d    = msu_sat;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ly_d    = $signed(ly_q) >>> exp_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything except the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_wait_q <= 1'b0;
      done_q    <= 1'b0;
      xaddr_q   <= '0;
      yaddr_q   <= '0;
      lx_q      <= '0;
      exp_q     <= '0;
      tab_q     <= '0;
      dif_q     <= '0;
      a_q       <= '0;
      ly_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_wait_q <= rd_wait_d;
      done_q    <= done_d;
      xaddr_q   <= xaddr_d;
      yaddr_q   <= yaddr_d;
      lx_q      <= lx_d;
      exp_q     <= exp_d;
      tab_q     <= tab_d;
      dif_q     <= dif_d;
      a_q       <= a_d;
      ly_q      <= ly_d;
    end
  end

endmodule

// File: tb/tb_inv_sqrt_pipe.sv
// Bench for inv_sqrt_pipe: directed literals, reset abort, then 600 random operands
// checked against a C-style Inv_sqrt model.
module tb_inv_sqrt_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] L_xAddr, L_yAddr;
  logic        sqrtMuxSel;
  logic [10:0] testReadAddr, testWriteAddr;
  logic [31:0] testMemOut;
  logic        testMemWriteEn;
  logic        done;
  logic [31:0] memIn;

  inv_sqrt_pipe dut (
    .clk(clk), .reset(reset), .start(start),
    .L_xAddr(L_xAddr), .L_yAddr(L_yAddr), .sqrtMuxSel(sqrtMuxSel),
    .testReadAddr(testReadAddr), .testWriteAddr(testWriteAddr),
    .testMemOut(testMemOut), .testMemWriteEn(testMemWriteEn),
    .done(done), .memIn(memIn)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int tabsqr_m [49] = '{32767,31790,30894,30070,29309,28602,27945,27330,26755,26214,
                        25705,25225,24770,24339,23930,23541,23170,22817,22479,22155,
                        21845,21548,21263,20988,20724,20470,20225,19988,19760,19539,
                        19326,19119,18919,18725,18536,18354,18176,18004,17837,17674,
                        17515,17361,17211,17064,16921,16782,16646,16514,16384};

  // Reference Inv_sqrt written the way the codec source reads.
  function automatic logic [31:0] ref_inv_sqrt(input logic [31:0] x);
    longint lx, ly;
    int e, i, a, tmp;
    if ($signed(x) <= 0) return 32'h3FFF_FFFF;
    lx = longint'(x);
    e  = 0;
    while (lx < 64'sh4000_0000) begin
      lx = lx * 2;
      e++;
    end
    e = 30 - e;
    if (e % 2 == 0) lx = lx / 2;
    e = e / 2 + 1;
    i   = int'(lx / 33554432) - 16;
    a   = int'((lx / 1024) % 32768);
    tmp = tabsqr_m[i] - tabsqr_m[i+1];
    ly  = longint'(tabsqr_m[i]) * 65536 - 2 * longint'(tmp) * longint'(a);
    if (ly > 64'sd2147483647)  ly = 64'sd2147483647;
    if (ly < -64'sd2147483648) ly = -64'sd2147483648;
    ly = ly >>> e;
    return ly[31:0];
  endfunction

  // Compare requests posted by the driver, evaluated on the falling edge.
  logic        cmp_mem = 1'b0, cmp_done = 1'b0, cmp_val = 1'b0;
  logic [31:0] cmp_exp = '0, cmp_got = '0;
  logic        cmp_done_exp = 1'b0;
  string       cmp_name = "";

  // Single compare process: memory readback, done level, and model pins.
  always @(negedge clk) begin
    if (cmp_mem) begin
      vectors++;
      if (memIn !== cmp_exp) begin
        miscompares++;
        $display("FAIL %s: memIn=%08h required %08h", cmp_name, memIn, cmp_exp);
      end
    end
    if (cmp_done) begin
      vectors++;
      if (done !== cmp_done_exp) begin
        miscompares++;
        $display("FAIL %s: done=%b required %b", cmp_name, done, cmp_done_exp);
      end
    end
    if (cmp_val) begin
      vectors++;
      if (cmp_got !== cmp_exp) begin
        miscompares++;
        $display("FAIL %s: model=%08h required %08h", cmp_name, cmp_got, cmp_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [10:0] ad, input logic [31:0] d);
    sqrtMuxSel     = 1'b1;
    testWriteAddr  = ad;
    testMemOut     = d;
    testMemWriteEn = 1'b1;
    tick();
    testMemWriteEn = 1'b0;
  endtask

  task automatic mem_chk(input logic [10:0] ad, input logic [31:0] e, input string nm);
    sqrtMuxSel   = 1'b1;
    testReadAddr = ad;
    tick();
    cmp_exp  = e;
    cmp_name = nm;
    cmp_mem  = 1'b1;
    tick();
    cmp_mem  = 1'b0;
  endtask

  task automatic done_chk(input logic e, input string nm);
    cmp_done_exp = e;
    cmp_name     = nm;
    cmp_done     = 1'b1;
    tick();
    cmp_done     = 1'b0;
  endtask

  task automatic model_pin(input logic [31:0] x, input logic [31:0] e, input string nm);
    cmp_got  = ref_inv_sqrt(x);
    cmp_exp  = e;
    cmp_name = nm;
    cmp_val  = 1'b1;
    tick();
    cmp_val  = 1'b0;
  endtask

  // One computation: pulse start, done must drop, then rise within 40 cycles and hold.
  task automatic run_op(input logic [10:0] xa, input logic [10:0] ya, input string nm);
    int n;
    sqrtMuxSel = 1'b0;
    L_xAddr    = xa;
    L_yAddr    = ya;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    done_chk(1'b0, {nm, "_done_low"});
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    done_chk(1'b1, {nm, "_done_high"});
  endtask

  logic [31:0] dir_x [6] = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
                             32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] dir_y [6] = '{32'h0000_7FFF, 32'h0000_5A82, 32'h3FFF_8000,
                             32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF};

  initial begin
    logic [31:0] x, r;
    logic [10:0] xa, ya;
    int sel;

    reset = 1'b1; start = 1'b0; L_xAddr = '0; L_yAddr = '0;
    sqrtMuxSel = 1'b1; testReadAddr = '0; testWriteAddr = '0;
    testMemOut = '0; testMemWriteEn = 1'b0;
    tick();
    done_chk(1'b0, "reset_done");
    reset = 1'b0;

    model_pin(32'h4000_0000, 32'h0000_7FFF, "pin_4000");
    model_pin(32'h7FFF_FFFF, 32'h0000_5A82, "pin_7fff");
    model_pin(32'h0000_0001, 32'h3FFF_8000, "pin_0001");

    for (int k = 0; k < 6; k++) begin
      mem_wr(11'd512, dir_x[k]);
      run_op(11'd512, 11'd1024, $sformatf("dir%0d", k));
      mem_chk(11'd1024, dir_y[k], $sformatf("dir%0d_result", k));
    end

    // Odd-exponent path without halving, checked against the model.
    mem_wr(11'd7, 32'h3FFF_FFFF);
    run_op(11'd7, 11'd8, "odd_exp");
    mem_chk(11'd8, ref_inv_sqrt(32'h3FFF_FFFF), "odd_exp_result");

    // Reset mid-computation: no write, done stays low.
    mem_wr(11'd100, 32'h1234_5678);
    mem_wr(11'd200, 32'hDEAD_BEEF);
    sqrtMuxSel = 1'b0; L_xAddr = 11'd100; L_yAddr = 11'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    done_chk(1'b0, "abort_done_in_reset");
    reset = 1'b0;
    repeat (12) tick();
    done_chk(1'b0, "abort_done_after");
    mem_chk(11'd200, 32'hDEAD_BEEF, "abort_no_write");

    // Start on the first edge after reset release.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_op(11'd100, 11'd200, "post_reset");
    mem_chk(11'd200, ref_inv_sqrt(32'h1234_5678), "post_reset_result");

    for (int k = 0; k < 600; k++) begin
      r   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: x = r;
        1, 2: x = r >> $urandom_range(0, 31);
        3: x = r & 32'h7FFF_FFFF;
        4: x = {1'b0, 1'b1, r[29:0]};
        default: begin
          case (r[1:0])
            2'd0: x = 32'h0000_0000;
            2'd1: x = 32'h8000_0000;
            2'd2: x = 32'h7FFF_FFFF;
            default: x = 32'h0000_0001;
          endcase
        end
      endcase
      xa = 11'($urandom_range(0, 1023));
      ya = 11'(1024 + $urandom_range(0, 1023));
      mem_wr(xa, x);
      run_op(xa, ya, "rand");
      mem_chk(ya, ref_inv_sqrt(x), $sformatf("rand%0d_x%08h", k, x));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
